// File: rtl/vga_timing_generator.sv
// Parametrised raster timing generator.
// Produces pixel/line counters, sync pulses of selectable polarity, a display
// enable, line/frame terminal flags and a wrapping frame counter. Counters
// advance only on clocks where pixel_enable is high.
//
// Ports:
//   clock           - rising-edge clock
//   reset           - synchronous active-high reset, overrides pixel_enable
//   pixel_enable    - advance strobe (one pixel per enabled clock)
//   hcount_output   - current pixel column
//   vcount_output   - current line
//   video_on        - high inside the active display area
//   horizontal_sync - horizontal sync, level H_SYNC_ACTIVE during the pulse
//   vertical_sync   - vertical sync, level V_SYNC_ACTIVE during the pulse
//   line_end        - high while hcount_output is the last column
//   frame_end       - high while at the last column of the last line
//   frame_count     - completed frames, wrapping
module vga_timing_generator #(
    parameter int unsigned H_DISPLAY     = 640,
    parameter int unsigned H_FRONT_PORCH = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BACK_PORCH  = 48,
    parameter int unsigned V_DISPLAY     = 480,
    parameter int unsigned V_FRONT_PORCH = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BACK_PORCH  = 33,
    parameter int unsigned H_SYNC_ACTIVE = 0,
    parameter int unsigned V_SYNC_ACTIVE = 0,
    parameter int unsigned COUNT_WIDTH   = 10,
    parameter int unsigned FRAME_WIDTH   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pixel_enable,
    output logic [COUNT_WIDTH-1:0] hcount_output,
    output logic [COUNT_WIDTH-1:0] vcount_output,
    output logic                   video_on,
    output logic                   horizontal_sync,
    output logic                   vertical_sync,
    output logic                   line_end,
    output logic                   frame_end,
    output logic [FRAME_WIDTH-1:0] frame_count
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;

    // Region boundaries expressed in counter width
    localparam logic [COUNT_WIDTH-1:0] H_LAST     = COUNT_WIDTH'(H_TOTAL - 1);
    localparam logic [COUNT_WIDTH-1:0] V_LAST     = COUNT_WIDTH'(V_TOTAL - 1);
    localparam logic [COUNT_WIDTH-1:0] H_ACT_END  = COUNT_WIDTH'(H_DISPLAY);
    localparam logic [COUNT_WIDTH-1:0] V_ACT_END  = COUNT_WIDTH'(V_DISPLAY);
    localparam logic [COUNT_WIDTH-1:0] HS_START   = COUNT_WIDTH'(H_DISPLAY + H_FRONT_PORCH);
    localparam logic [COUNT_WIDTH-1:0] HS_END     = COUNT_WIDTH'(H_DISPLAY + H_FRONT_PORCH + H_SYNC);
    localparam logic [COUNT_WIDTH-1:0] VS_START   = COUNT_WIDTH'(V_DISPLAY + V_FRONT_PORCH);
    localparam logic [COUNT_WIDTH-1:0] VS_END     = COUNT_WIDTH'(V_DISPLAY + V_FRONT_PORCH + V_SYNC);
    localparam logic                   HS_LEVEL   = 1'(H_SYNC_ACTIVE);
    localparam logic                   VS_LEVEL   = 1'(V_SYNC_ACTIVE);

    // Reject modes that cannot be represented
    if (H_DISPLAY < 1 || H_FRONT_PORCH < 1 || H_SYNC < 1 || H_BACK_PORCH < 1 ||
        V_DISPLAY < 1 || V_FRONT_PORCH < 1 || V_SYNC < 1 || V_BACK_PORCH < 1) begin : g_bad_timing
        $fatal(1, "vga_timing_generator: every timing parameter must be at least 1");
    end
    if ((64'd1 << COUNT_WIDTH) <= 64'(H_TOTAL - 1) ||
        (64'd1 << COUNT_WIDTH) <= 64'(V_TOTAL - 1)) begin : g_bad_width
        $fatal(1, "vga_timing_generator: COUNT_WIDTH too small for the mode");
    end

    logic [COUNT_WIDTH-1:0] hcount_next;
    logic [COUNT_WIDTH-1:0] vcount_next;
    logic [FRAME_WIDTH-1:0] frame_next;
    logic                   video_on_next;
    logic                   horizontal_sync_next;
    logic                   vertical_sync_next;
    logic                   line_end_next;
    logic                   frame_end_next;

    // Counter advance; without pixel_enable everything holds
    always_comb begin
        hcount_next = hcount_output;
        vcount_next = vcount_output;
        frame_next  = frame_count;
        if (pixel_enable) begin
            if (hcount_output == H_LAST) begin
                hcount_next = '0;
                if (vcount_output == V_LAST) begin
                    vcount_next = '0;
                    frame_next  = frame_count + FRAME_WIDTH'(1);
                end else begin
                    vcount_next = vcount_output + COUNT_WIDTH'(1);
                end
            end else begin
                hcount_next = hcount_output + COUNT_WIDTH'(1);
            end
        end
    end

    // Decodes on the next counter values so the registered outputs line up
    // with the counters they describe
    always_comb begin
        video_on_next        = (hcount_next < H_ACT_END) && (vcount_next < V_ACT_END);
        horizontal_sync_next = ((hcount_next >= HS_START) && (hcount_next < HS_END)) ? HS_LEVEL : ~HS_LEVEL;
        vertical_sync_next   = ((vcount_next >= VS_START) && (vcount_next < VS_END)) ? VS_LEVEL : ~VS_LEVEL;
        line_end_next        = (hcount_next == H_LAST);
        frame_end_next       = (hcount_next == H_LAST) && (vcount_next == V_LAST);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            hcount_output   <= '0;
            vcount_output   <= '0;
            frame_count     <= '0;
            video_on        <= 1'b1;
            horizontal_sync <= ~HS_LEVEL;
            vertical_sync   <= ~VS_LEVEL;
            line_end        <= 1'b0;
            frame_end       <= 1'b0;
        end else begin
            hcount_output   <= hcount_next;
            vcount_output   <= vcount_next;
            frame_count     <= frame_next;
            video_on        <= video_on_next;
            horizontal_sync <= horizontal_sync_next;
            vertical_sync   <= vertical_sync_next;
            line_end        <= line_end_next;
            frame_end       <= frame_end_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Testbench for vga_timing_generator: a default 640x480 instance and a small
// mode instance (active-high hsync, 2-bit frame counter) share one stimulus.
// Expected outputs come from the count of enabled clocks since reset.
module tb_vga_timing_generator;

    // Small mode: H 8/2/3/2 (total 15), V 5/1/2/3 (total 11)
    localparam int S_HD = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VD = 5, S_VF = 1, S_VS = 2, S_VB = 3;
    localparam int S_HT = S_HD + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VD + S_VF + S_VS + S_VB;

    logic clock = 1'b0;
    logic reset;
    logic pixel_enable;

    logic [9:0] d_h, d_v;
    logic [7:0] d_f;
    logic       d_von, d_hs, d_vs, d_le, d_fe;

    logic [4:0] s_h, s_v;
    logic [1:0] s_f;
    logic       s_von, s_hs, s_vs, s_le, s_fe;

    int checks = 0;
    int errors = 0;
    int ticks  = 0;

    typedef struct {
        int h;
        int v;
        int f;
        bit von;
        bit hs;
        bit vs;
        bit le;
        bit fe;
    } exp_t;

    always #5 clock = ~clock;

    vga_timing_generator u_default (
        .clock           (clock),
        .reset           (reset),
        .pixel_enable    (pixel_enable),
        .hcount_output   (d_h),
        .vcount_output   (d_v),
        .video_on        (d_von),
        .horizontal_sync (d_hs),
        .vertical_sync   (d_vs),
        .line_end        (d_le),
        .frame_end       (d_fe),
        .frame_count     (d_f)
    );

    vga_timing_generator #(
        .H_DISPLAY     (S_HD),
        .H_FRONT_PORCH (S_HF),
        .H_SYNC        (S_HS),
        .H_BACK_PORCH  (S_HB),
        .V_DISPLAY     (S_VD),
        .V_FRONT_PORCH (S_VF),
        .V_SYNC        (S_VS),
        .V_BACK_PORCH  (S_VB),
        .H_SYNC_ACTIVE (1),
        .V_SYNC_ACTIVE (0),
        .COUNT_WIDTH   (5),
        .FRAME_WIDTH   (2)
    ) u_small (
        .clock           (clock),
        .reset           (reset),
        .pixel_enable    (pixel_enable),
        .hcount_output   (s_h),
        .vcount_output   (s_v),
        .video_on        (s_von),
        .horizontal_sync (s_hs),
        .vertical_sync   (s_vs),
        .line_end        (s_le),
        .frame_end       (s_fe),
        .frame_count     (s_f)
    );

    // Position after t enabled clocks, from the raster definition
    function automatic exp_t model(input int t, input int hd, input int hf, input int hs,
                                   input int hb, input int vd, input int vf, input int vs,
                                   input int vb, input bit ha, input bit va, input int fw);
        exp_t e;
        int ht, vt, line;
        ht     = hd + hf + hs + hb;
        vt     = vd + vf + vs + vb;
        e.h    = t % ht;
        line   = t / ht;
        e.v    = line % vt;
        e.f    = (line / vt) % (1 << fw);
        e.von  = (e.h < hd) && (e.v < vd);
        e.hs   = (e.h >= hd + hf && e.h < hd + hf + hs) ? ha : !ha;
        e.vs   = (e.v >= vd + vf && e.v < vd + vf + vs) ? va : !va;
        e.le   = (e.h == ht - 1);
        e.fe   = e.le && (e.v == vt - 1);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0d expected=%0d", tag, ticks, got, exp);
        end
    endtask

    task automatic check_all();
        exp_t ed, es;
        ed = model(ticks, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8);
        es = model(ticks, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, 1'b1, 1'b0, 2);
        check("d_hcount",   32'(d_h),   32'(ed.h));
        check("d_vcount",   32'(d_v),   32'(ed.v));
        check("d_frame",    32'(d_f),   32'(ed.f));
        check("d_video_on", 32'(d_von), 32'(ed.von));
        check("d_hsync",    32'(d_hs),  32'(ed.hs));
        check("d_vsync",    32'(d_vs),  32'(ed.vs));
        check("d_line_end", 32'(d_le),  32'(ed.le));
        check("d_frame_end",32'(d_fe),  32'(ed.fe));
        check("s_hcount",   32'(s_h),   32'(es.h));
        check("s_vcount",   32'(s_v),   32'(es.v));
        check("s_frame",    32'(s_f),   32'(es.f));
        check("s_video_on", 32'(s_von), 32'(es.von));
        check("s_hsync",    32'(s_hs),  32'(es.hs));
        check("s_vsync",    32'(s_vs),  32'(es.vs));
        check("s_line_end", 32'(s_le),  32'(es.le));
        check("s_frame_end",32'(s_fe),  32'(es.fe));
    endtask

    // Apply one clock with the given inputs, advance the model, compare
    task automatic step(input logic rst, input logic en);
        reset        = rst;
        pixel_enable = en;
        @(posedge clock);
        #1;
        if (rst)     ticks = 0;
        else if (en) ticks++;
        check_all();
    endtask

    initial begin
        reset        = 1'b1;
        pixel_enable = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        ticks = 0;
        check_all();

        // Continuous enable: several default lines, many small frames
        for (int i = 0; i < 2500; i++) step(1'b0, 1'b1);

        // Alternating enable, starting from a fresh reset
        step(1'b1, 1'b0);
        for (int i = 0; i < 1000; i++) step(1'b0, 1'(i % 2 == 0));

        // Reset while both small-mode syncs are active, enable high then low
        step(1'b1, 1'b1);
        for (int i = 0; i < (S_VD + S_VF) * S_HT + S_HD + S_HF + 1; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < (S_VD + S_VF) * S_HT + S_HD + S_HF + 1; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1);

        // Random enable with occasional resets
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Parametrised VGA/raster timing generator. It produces horizontal and vertical pixel counters, sync pulses of configurable polarity, a display-enable signal, line/frame terminal flags and a frame counter. It sits between the pixel-clock domain and the pixel-source/colour-output logic, and supports any mode through its parameters (640x480@60 by default). Advance is gated by a pixel-enable strobe, so it runs from a faster system clock.

## Interface
- H_DISPLAY, 640, active pixels per line
- H_FRONT_PORCH, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK_PORCH, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, active lines per frame
- V_FRONT_PORCH, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK_PORCH, 33, vertical back porch (lines)
- H_SYNC_ACTIVE, 0, level of horizontal_sync during the sync pulse
- V_SYNC_ACTIVE, 0, level of vertical_sync during the sync pulse
- COUNT_WIDTH, 10, width of hcount_output/vcount_output
- FRAME_WIDTH, 8, width of frame_count

Ports:
- clock  in  1  single clock; all logic is rising-edge
- reset  in  1  synchronous, active-high; priority over everything
- pixel_enable  in  1  counters advance only on clocks where high
- hcount_output  out  COUNT_WIDTH  current pixel column
- vcount_output  out  COUNT_WIDTH  current line
- video_on  out  1  high inside the active area
- horizontal_sync  out  1  horizontal sync, polarity per H_SYNC_ACTIVE
- vertical_sync  out  1  vertical sync, polarity per V_SYNC_ACTIVE
- line_end  out  1  high while hcount_output == H_TOTAL-1
- frame_end  out  1  high while at (H_TOTAL-1, V_TOTAL-1)
- frame_count  out  FRAME_WIDTH  completed frames, modulo 2^FRAME_WIDTH

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT_PORCH+H_SYNC+H_BACK_PORCH.
- V_TOTAL = V_DISPLAY+V_FRONT_PORCH+V_SYNC+V_BACK_PORCH.
- Region order per line/frame: display, front porch, sync, back porch.
- Elaboration check (fatal): every timing parameter must be ≥1. 2^COUNT_WIDTH must be > H_TOTAL-1 and > V_TOTAL-1.
- Counter update on clock with pixel_enable=1 and reset=0:
  - hcount < H_TOTAL-1: hcount+1.
  - Otherwise: hcount→0 and the vertical counter steps.
  - Vertical step: vcount+1, or vcount→0 when vcount==V_TOTAL-1. frame_count increments (wrapping) on that same clock.
- pixel_enable=0: every register and output holds its value.
- Decodes, evaluated on the (hcount, vcount) presented in the same cycle:
  - video_on = hcount<H_DISPLAY && vcount<V_DISPLAY.
  - horizontal_sync = H_SYNC_ACTIVE when H_DISPLAY+H_FRONT_PORCH ≤ hcount < H_DISPLAY+H_FRONT_PORCH+H_SYNC. Otherwise it is the inverse of H_SYNC_ACTIVE.
  - vertical_sync uses the same rule with the V parameters and vcount. It changes only together with vcount.
  - line_end and frame_end follow their definitions in the port list.
- Outputs are registered: sync/video_on/flags are computed from next-state counter values. All outputs change on the same edge as the counters and are glitch-free.
- Reset values:
  - hcount_output=0, vcount_output=0, frame_count=0.
  - video_on=1.
  - horizontal_sync=~H_SYNC_ACTIVE, vertical_sync=~V_SYNC_ACTIVE.
  - line_end=0, frame_end=0.

## Timing
- Latency: the first counter advance is on the first clock with pixel_enable=1 after reset deasserts.
- line_end and frame_end are levels, held for as many clocks as the terminal count is held. Consumers qualify them with pixel_enable to get one pulse per line/frame.
- Horizontal sync spans exactly H_SYNC enabled clocks per line.
- Vertical sync spans exactly V_SYNC×H_TOTAL enabled clocks. It asserts on the edge where hcount wraps to 0 entering line V_DISPLAY+V_FRONT_PORCH.
- Simultaneous reset and pixel_enable: reset wins.
- Reset mid-line/mid-sync: the next clock shows the reset values. No partial sync pulse is extended.
- Wrap at (H_TOTAL-1, V_TOTAL-1) is a single edge: both counters→0, frame_count+1, frame_end→0, video_on→1.

## Test plan
- **Line timing.** Reset, then 800 clocks with pixel_enable=1.
  - hcount runs 0..799 then back to 0, and vcount becomes 1 on the 800th edge.
  - horizontal_sync is low exactly at hcount 656..751.
  - video_on is high exactly at hcount 0..639.
- **Full frame.** 420000 enabled clocks.
  - vertical_sync is low for vcount 490..491 (1600 clocks).
  - video_on is high for 307200 clocks.
  - frame_end is high for one clock at (799,524).
  - frame_count goes 0→1 and both counters return to 0.
- **Pixel enable gating.** pixel_enable alternates 1,0.
  - Counters advance every other clock and all outputs hold during the 0 clocks.
  - line_end is held for 2 clocks when the enable-low cycle falls on hcount 799.
- **Reset mid-operation.** Assert reset at hcount 700, vcount 491 (both syncs active), with pixel_enable both 1 and 0.
  - Next clock: all outputs show reset values.
  - After release, hsync first asserts at hcount 656.
- **720p override.**
  - Parameters: 1280/110/40/220, 720/5/5/20, COUNT_WIDTH=11, H_SYNC_ACTIVE=1, V_SYNC_ACTIVE=1.
  - Expected: H_TOTAL=1650, hsync high at hcount 1390..1429, V_TOTAL=750, vsync high at vcount 725..729.
- **Frame counter wrap.** FRAME_WIDTH=2, with reduced timing parameters (all 1, display 4x4) to shorten simulation.
  - frame_count goes 0,1,2,3,0 over 4 frames, each step on the frame_end edge.
